countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
Loadable down-counter and timer. It is the decrementing counterpart of the team's up-counter: it counts from a preloaded value down to terminal count.
Emits a one-cycle terminal-count pulse and supports one-shot and auto-reload (periodic) modes. It is used as the tick and period generator beside the up-counter in the lab datapath.

Parameters:
WIDTH, 8, bit width of preload value, reload register and count.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
clr  input  1  synchronous abort: count to 0, state to IDLE
load  input  1  preload count and reload register from v
v  input  WIDTH  value to preload
en  input  1  decrement enable; low while RUN means pause/hold
auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled at terminal count
count  output  WIDTH  current count
tc  output  1  terminal-count pulse, one cycle wide
busy  output  1  high while state == RUN
done  output  1  sticky one-shot completion flag (state == DONE)

Behaviour:
- Reset (async, rst=1):
  - count=0, internal reload register=0, state=IDLE.
  - tc=0, busy=0, done=0.
  - Takes effect immediately and overrides everything, including mid-count.
- State machine: IDLE, RUN, DONE. All outputs are registered.
- Priority each cycle: rst > clr > load > decrement.
- clr=1, any state:
  - count<=0, state<=IDLE, tc<=0.
  - Reload register is kept.
- load=1 (clr=0), any state:
  - reload<=v.
  - If v!=0: count<=v, state<=RUN.
  - If v==0: count<=0, state<=IDLE.
  - tc<=0 and done clears.
  - A load in the same cycle as a would-be terminal count suppresses that tc.
- RUN, en=0: count and state hold (pause); tc<=0.
- RUN, en=1, count>1: count<=count-1 (WIDTH-bit); tc<=0.
- RUN, en=1, count==1 (terminal):
  - tc<=1 for exactly one cycle.
  - auto_reload=1: count<=reload, state stays RUN. Period = reload cycles when en is held high.
  - auto_reload=0: count<=0, state<=DONE.
- IDLE and DONE: count holds; en is ignored; tc=0.
- count never underflows or wraps. In RUN, count is always >= 1.
- tc is high in the cycle where count first shows 0 (one-shot) or the reloaded value (periodic).
- Reload register changes only on load, never on decrement.
- Maximum count is 2^WIDTH-1. A load of all-ones counts the full range.
- Latency:
  - Load to first visible count: 1 cycle.
  - Counting starts on the first en=1 edge after count==v is visible.

Test Plan:
- Reset: assert rst mid-RUN with count=5, asynchronously between edges -> count=0, busy=0, done=0, tc=0 immediately. After release, no activity until load.
- One-shot: load v=3, auto_reload=0, en=1 held.
  - Expected count sequence: 3,2,1,0.
  - tc=1 only in the cycle count shows 0; then done=1, busy=0, count stays 0.
- Periodic: load v=4, auto_reload=1, en=1 held for 12 cycles.
  - count cycles 4,3,2,1,4,3,2,1,...
  - tc pulses every 4 cycles, coincident with count showing 4; busy stays 1.
- Pause: load v=6, en=1 for 2 cycles (count 4), en=0 for 3 cycles (count holds 4, tc=0), en=1 again -> 3,2,1,0 with tc at 0.
- Priority/collision:
  - count==1 & en=1 & load=1 with v=9 -> count=9, tc=0, state RUN.
  - Same cycle with clr=1 also asserted -> count=0, IDLE, tc=0.
- Boundaries:
  - load v=0 -> IDLE, count=0, no tc.
  - load v=255 (WIDTH=8) -> 255 decrements to 0 with a single tc, no wrap.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse,
// one-shot and auto-reload (periodic) modes.
module countdown_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] v,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, done_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (clr) begin
            count_d = '0;
            state_d = StIdle;
        end else if (load) begin
            reload_d = v;
            if (v != '0) begin
                count_d = v;
                state_d = StRun;
            end else begin
                count_d = '0;
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (en) begin
                        if (count_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
                            // auto_reload is only looked at here, at terminal count
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = StDone;
                            end
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                StIdle, StDone: begin
                    count_d = count_q;
                end
                default: begin
                    count_d = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= (state_d == StRun);
            done_q   <= (state_d == StDone);
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table plus hand-written
// periodic, full-range and asynchronous-reset sequences, via a scoreboard queue.
module tb_countdown_timer;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       load;
    logic [7:0] v;
    logic       en;
    logic       auto_reload;
    logic [7:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .load        (load),
        .v           (v),
        .en          (en),
        .auto_reload (auto_reload),
        .count       (count),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] count;
        logic       tc;
        logic       busy;
        logic       done;
        string      name;
    } exp_t;

    typedef struct {
        logic       clr;
        logic       load;
        logic [7:0] v;
        logic       en;
        logic       ar;
        logic [7:0] count;
        logic       tc;
        logic       busy;
        logic       done;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[26];

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (count !== e.count || tc !== e.tc || busy !== e.busy || done !== e.done) begin
            errors++;
            $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b, required count=%0d tc=%b busy=%b done=%b",
                     e.name, count, tc, busy, done, e.count, e.tc, e.busy, e.done);
        end
    endtask

    // Drive inputs now, expect the given outputs after the next rising edge.
    task automatic step(input logic c, input logic l, input logic [7:0] vv, input logic e,
                        input logic a, input logic [7:0] ec, input logic et, input logic eb,
                        input logic ed, input string nm);
        clr = c; load = l; v = vv; en = e; auto_reload = a;
        sb.push_back('{count: ec, tc: et, busy: eb, done: ed, name: nm});
        @(posedge clk);
        #1;
        compare_next();
    endtask

    initial begin
        tbl[0]  = '{0, 1, 8'd3, 1, 0, 8'd3, 0, 1, 0};  // one-shot load 3
        tbl[1]  = '{0, 0, 8'd0, 1, 0, 8'd2, 0, 1, 0};
        tbl[2]  = '{0, 0, 8'd0, 1, 0, 8'd1, 0, 1, 0};
        tbl[3]  = '{0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 1};
        tbl[4]  = '{0, 0, 8'd0, 1, 0, 8'd0, 0, 0, 1};
        tbl[5]  = '{0, 1, 8'd6, 1, 0, 8'd6, 0, 1, 0};  // pause sequence
        tbl[6]  = '{0, 0, 8'd0, 1, 0, 8'd5, 0, 1, 0};
        tbl[7]  = '{0, 0, 8'd0, 1, 0, 8'd4, 0, 1, 0};
        tbl[8]  = '{0, 0, 8'd0, 0, 0, 8'd4, 0, 1, 0};
        tbl[9]  = '{0, 0, 8'd0, 0, 0, 8'd4, 0, 1, 0};
        tbl[10] = '{0, 0, 8'd0, 0, 0, 8'd4, 0, 1, 0};
        tbl[11] = '{0, 0, 8'd0, 1, 0, 8'd3, 0, 1, 0};
        tbl[12] = '{0, 0, 8'd0, 1, 0, 8'd2, 0, 1, 0};
        tbl[13] = '{0, 0, 8'd0, 1, 0, 8'd1, 0, 1, 0};
        tbl[14] = '{0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 1};
        tbl[15] = '{0, 1, 8'd2, 1, 0, 8'd2, 0, 1, 0};  // load at terminal count
        tbl[16] = '{0, 0, 8'd0, 1, 0, 8'd1, 0, 1, 0};
        tbl[17] = '{0, 1, 8'd9, 1, 0, 8'd9, 0, 1, 0};
        tbl[18] = '{0, 0, 8'd0, 1, 0, 8'd8, 0, 1, 0};
        tbl[19] = '{0, 1, 8'd1, 0, 0, 8'd1, 0, 1, 0};  // clr beats load at terminal
        tbl[20] = '{1, 1, 8'd9, 1, 0, 8'd0, 0, 0, 0};
        tbl[21] = '{0, 0, 8'd0, 1, 0, 8'd0, 0, 0, 0};
        tbl[22] = '{0, 1, 8'd0, 1, 0, 8'd0, 0, 0, 0};  // load of zero
        tbl[23] = '{0, 0, 8'd0, 1, 0, 8'd0, 0, 0, 0};
        tbl[24] = '{0, 1, 8'd7, 1, 0, 8'd7, 0, 1, 0};  // clr mid-run
        tbl[25] = '{1, 0, 8'd0, 1, 0, 8'd0, 0, 0, 0};

        rst = 1'b1; clr = 1'b0; load = 1'b0; v = 8'd0; en = 1'b0; auto_reload = 1'b0;
        #1;
        sb.push_back('{count: 8'd0, tc: 1'b0, busy: 1'b0, done: 1'b0, name: "reset_state"});
        compare_next();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].clr, tbl[i].load, tbl[i].v, tbl[i].en, tbl[i].ar,
                 tbl[i].count, tbl[i].tc, tbl[i].busy, tbl[i].done, $sformatf("vec_%0d", i));
        end

        // Periodic: period 4, tc coincides with the reloaded value.
        step(0, 1, 8'd4, 1, 1, 8'd4, 0, 1, 0, "periodic_load");
        for (int i = 1; i <= 12; i++) begin
            logic [7:0] ec;
            ec = (i % 4 == 0) ? 8'd4 : 8'(4 - (i % 4));
            step(0, 0, 8'd0, 1, 1, ec, (i % 4 == 0), 1, 0, $sformatf("periodic_%0d", i));
        end
        // Dropping auto_reload before the next terminal count ends in one-shot fashion.
        step(0, 0, 8'd0, 1, 0, 8'd3, 0, 1, 0, "periodic_to_oneshot_3");
        step(0, 0, 8'd0, 1, 0, 8'd2, 0, 1, 0, "periodic_to_oneshot_2");
        step(0, 0, 8'd0, 1, 0, 8'd1, 0, 1, 0, "periodic_to_oneshot_1");
        step(0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 1, "periodic_to_oneshot_0");

        // Full range: 255 down to 0 with a single tc and no wrap.
        step(0, 1, 8'd255, 1, 0, 8'd255, 0, 1, 0, "full_load");
        for (int i = 1; i <= 255; i++) begin
            step(0, 0, 8'd0, 1, 0, 8'(255 - i), (i == 255), (i < 255), (i == 255),
                 $sformatf("full_%0d", i));
        end
        step(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, 1, "full_no_wrap");

        // Asynchronous reset between edges while running at count 5.
        step(0, 1, 8'd5, 0, 0, 8'd5, 0, 1, 0, "async_pre_load");
        load = 1'b0;
        en = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        sb.push_back('{count: 8'd0, tc: 1'b0, busy: 1'b0, done: 1'b0, name: "async_reset"});
        compare_next();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, 0, "post_reset_idle_1");
        step(0, 0, 8'd0, 1, 1, 8'd0, 0, 0, 0, "post_reset_idle_2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
